// File: rtl/regfile_param_if.sv
// Register-file bus: read ports, write port and the dump stream handshake.
// master = pipeline/debug side, slave = the register file.
interface regfile_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 4
);
  logic              rd_en;
  logic [AW-1:0]     ra1;
  logic [AW-1:0]     ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;
  logic              dump_req;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [AW-1:0]     dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;

  modport master (
    output rd_en, ra1, ra2, we, wa, wd, dump_req, dump_ready,
    input  rd1, rd2, dump_busy, dump_valid, dump_addr, dump_data, dump_done
  );

  modport slave (
    input  rd_en, ra1, ra2, we, wa, wd, dump_req, dump_ready,
    output rd1, rd2, dump_busy, dump_valid, dump_addr, dump_data, dump_done
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: 2 registered read ports, 1 write port, streaming dump engine.
// Define RF_BYPASS_EN for write-first same-cycle forwarding; default is read-first.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned AW       = $clog2(NUM_REGS),
  parameter int unsigned ZERO_REG = 0
) (
  input logic            clk,
  input logic            rst,
  regfile_param_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} dump_state_e;

  localparam logic [AW:0]   NumRegsW = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0] LastAddr = AW'(NUM_REGS - 1);

  logic [DATA_W-1:0] bank_q [NUM_REGS];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              wr_legal;

  dump_state_e       state_q;
  logic              dump_valid_q;
  logic              dump_busy_q;
  logic              dump_done_q;
  logic [AW-1:0]     dump_addr_q;

  // An address maps to real storage: in range and not the hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < NumRegsW) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_legal = bus.we && addr_live(bus.wa);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (wr_legal) begin
      bank_q[bus.wa] <= bus.wd;
    end
  end

  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (bus.rd_en) begin
      rd1_d = addr_live(bus.ra1) ? bank_q[bus.ra1] : '0;
      rd2_d = addr_live(bus.ra2) ? bank_q[bus.ra2] : '0;
`ifdef RF_BYPASS_EN
      if (wr_legal && (bus.wa == bus.ra1)) rd1_d = bus.wd;
      if (wr_legal && (bus.wa == bus.ra2)) rd2_d = bus.wd;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      dump_valid_q <= 1'b0;
      dump_busy_q  <= 1'b0;
      dump_done_q  <= 1'b0;
      dump_addr_q  <= '0;
    end else begin
      dump_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.dump_req) begin
            state_q      <= StRun;
            dump_valid_q <= 1'b1;
            dump_busy_q  <= 1'b1;
            dump_addr_q  <= '0;
          end
        end
        StRun: begin
          if (dump_valid_q && bus.dump_ready) begin
            if (dump_addr_q == LastAddr) begin
              state_q      <= StDone;
              dump_valid_q <= 1'b0;
              dump_done_q  <= 1'b1;
            end else begin
              dump_addr_q <= dump_addr_q + AW'(1);
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          dump_busy_q <= 1'b0;
          dump_addr_q <= '0;
        end
        default: begin
          state_q      <= StIdle;
          dump_valid_q <= 1'b0;
          dump_busy_q  <= 1'b0;
          dump_addr_q  <= '0;
        end
      endcase
    end
  end

  // Live view of the bank: a write to the stalled entry shows up before acceptance.
  assign bus.dump_data  = addr_live(dump_addr_q) ? bank_q[dump_addr_q] : '0;
  assign bus.dump_addr  = dump_addr_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_busy  = dump_busy_q;
  assign bus.dump_done  = dump_done_q;
  assign bus.rd1        = rd1_q;
  assign bus.rd2        = rd2_q;

  a_done_framed: assert property (@(posedge clk) disable iff (!rst)
    dump_done_q |-> (dump_busy_q && !dump_valid_q));

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: read scoreboard, dump scoreboard,
// ZERO_REG/out-of-range instance and mid-dump reset.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_param_if #(.DATA_W(32), .AW(4)) bus0 ();
  regfile_param_if #(.DATA_W(32), .AW(4)) bus1 ();

  regfile_param #(.DATA_W(32), .NUM_REGS(16), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  regfile_param #(.DATA_W(32), .NUM_REGS(12), .ZERO_REG(1)) u_dut_zero (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int          n_cmp    = 0;
  int          n_err    = 0;
  int          done_cnt = 0;
  int          acc_cnt  = 0;
  logic        rd_fire  = 1'b0;
  logic [31:0] model [16];
  logic [31:0] q_rd1 [$];
  logic [31:0] q_rd2 [$];
  logic [3:0]  q_dump [$];
  logic [3:0]  ea;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Push expected read data before the edge; commit writes to the model at the edge.
  task automatic tick();
    logic [31:0] e1, e2, wdat;
    logic        do_wr;
    logic [3:0]  wadr;
    do_wr = bus0.we;
    wadr  = bus0.wa;
    wdat  = bus0.wd;
    if (bus0.rd_en) begin
      e1 = model[bus0.ra1];
      e2 = model[bus0.ra2];
`ifdef RF_BYPASS_EN
      if (bus0.we && (bus0.wa == bus0.ra1)) e1 = bus0.wd;
      if (bus0.we && (bus0.wa == bus0.ra2)) e2 = bus0.wd;
`endif
      q_rd1.push_back(e1);
      q_rd2.push_back(e2);
    end
    @(posedge clk);
    if (do_wr) model[wadr] = wdat;
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus0.we = 1'b1;
    bus0.wa = a;
    bus0.wd = d;
    tick();
    bus0.we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
    bus0.rd_en = 1'b1;
    bus0.ra1   = a1;
    bus0.ra2   = a2;
    tick();
    bus0.rd_en = 1'b0;
  endtask

  always @(posedge clk) rd_fire <= bus0.rd_en && rst;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (q_rd1.size() == 0) begin
        check("rd_sb_depth", 32'(q_rd1.size()), 32'd1);
      end else begin
        check("rd1", bus0.rd1, q_rd1.pop_front());
        check("rd2", bus0.rd2, q_rd2.pop_front());
      end
    end
    if (rst && bus0.dump_valid && bus0.dump_ready) begin
      acc_cnt++;
      if (q_dump.size() == 0) begin
        check("dump_sb_depth", 32'(q_dump.size()), 32'd1);
      end else begin
        ea = q_dump.pop_front();
        check("dump_addr", 32'(bus0.dump_addr), 32'(ea));
        check("dump_data", bus0.dump_data, model[ea]);
      end
    end
    if (bus0.dump_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int d0, a0, n;
    for (int i = 0; i < 16; i++) model[i] = '0;
    bus0.rd_en = 0; bus0.ra1 = '0; bus0.ra2 = '0; bus0.we = 0; bus0.wa = '0; bus0.wd = '0;
    bus0.dump_req = 0; bus0.dump_ready = 0;
    bus1.rd_en = 0; bus1.ra1 = '0; bus1.ra2 = '0; bus1.we = 0; bus1.wa = '0; bus1.wd = '0;
    bus1.dump_req = 0; bus1.dump_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    check("rst_rd1", bus0.rd1, 32'd0);
    check("rst_rd2", bus0.rd2, 32'd0);
    check("rst_valid", 32'(bus0.dump_valid), 32'd0);
    check("rst_busy", 32'(bus0.dump_busy), 32'd0);

    // Write then read next cycle, then hold with rd_en low.
    wr(4'd5, 32'hDEAD_BEEF);
    rd(4'd5, 4'd3);
    bus0.ra1 = 4'd3;
    tick();
    check("rd1_hold", bus0.rd1, 32'hDEAD_BEEF);
    check("rd2_hold", bus0.rd2, 32'd0);

    // Same-cycle write and read of one address.
    wr(4'd7, 32'h11);
    bus0.we = 1'b1; bus0.wa = 4'd7; bus0.wd = 32'h22;
    bus0.rd_en = 1'b1; bus0.ra1 = 4'd7; bus0.ra2 = 4'd5;
    tick();
    bus0.we = 1'b0; bus0.rd_en = 1'b0;
    rd(4'd7, 4'd7);

    for (int i = 0; i < 16; i++) wr(4'(i), 32'(i * 3));
    for (int i = 0; i < 8; i++) rd(4'(i), 4'(15 - i));

    // Full dump with toggling backpressure.
    for (int i = 0; i < 16; i++) q_dump.push_back(4'(i));
    d0 = done_cnt; a0 = acc_cnt;
    bus0.dump_req = 1'b1; bus0.dump_ready = 1'b0;
    tick();
    bus0.dump_req = 1'b0;
    check("first_valid", 32'(bus0.dump_valid), 32'd1);
    check("first_addr", 32'(bus0.dump_addr), 32'd0);
    check("first_busy", 32'(bus0.dump_busy), 32'd1);
    for (int c = 0; c < 100; c++) begin
      if (done_cnt != d0) break;
      bus0.dump_ready = (c % 2 == 0);
      tick();
      if (bus0.dump_done) check("done_busy", 32'(bus0.dump_busy), 32'd1);
    end
    bus0.dump_ready = 1'b0;
    tick(); tick();
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("dump_accepts", 32'(acc_cnt - a0), 32'd16);
    check("dump_sb_left", 32'(q_dump.size()), 32'd0);
    check("busy_after", 32'(bus0.dump_busy), 32'd0);

    // Stall at entry 4, overwrite it, then reset at entry 9.
    for (int i = 0; i < 16; i++) q_dump.push_back(4'(i));
    bus0.dump_req = 1'b1;
    tick();
    bus0.dump_req = 1'b0;
    bus0.dump_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus0.dump_addr == 4'd4) break;
      tick();
    end
    bus0.dump_ready = 1'b0;
    check("stall_addr", 32'(bus0.dump_addr), 32'd4);
    wr(4'd4, 32'hAA);
    check("stall_addr_hold", 32'(bus0.dump_addr), 32'd4);
    check("stall_data", bus0.dump_data, 32'hAA);
    bus0.dump_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus0.dump_addr == 4'd9) break;
      tick();
    end
    check("pre_rst_addr", 32'(bus0.dump_addr), 32'd9);
    rst = 1'b0;
    d0 = done_cnt;
    #1;
    check("mid_rst_valid", 32'(bus0.dump_valid), 32'd0);
    check("mid_rst_busy", 32'(bus0.dump_busy), 32'd0);
    check("mid_rst_addr", 32'(bus0.dump_addr), 32'd0);
    check("mid_rst_rd1", bus0.rd1, 32'd0);
    check("mid_rst_rd2", bus0.rd2, 32'd0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    q_dump.delete();
    bus0.dump_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    repeat (3) tick();
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    for (int i = 0; i < 16; i += 2) rd(4'(i), 4'(i + 1));

    // ZERO_REG=1, NUM_REGS=12 instance: reg 0 and out-of-range accesses.
    bus1.we = 1'b1;
    bus1.wa = 4'd0;  bus1.wd = 32'h1234; tick();
    bus1.wa = 4'd1;  bus1.wd = 32'h55;   tick();
    bus1.wa = 4'd13; bus1.wd = 32'h99;   tick();
    bus1.wa = 4'd11; bus1.wd = 32'h77;   tick();
    bus1.we = 1'b0;
    bus1.rd_en = 1'b1; bus1.ra1 = 4'd0; bus1.ra2 = 4'd1; tick();
    check("z_reg0", bus1.rd1, 32'd0);
    check("z_reg1", bus1.rd2, 32'h55);
    bus1.ra1 = 4'd13; bus1.ra2 = 4'd11; tick();
    bus1.rd_en = 1'b0;
    check("z_oob", bus1.rd1, 32'd0);
    check("z_reg11", bus1.rd2, 32'h77);
    bus1.dump_req = 1'b1; bus1.dump_ready = 1'b1;
    tick();
    bus1.dump_req = 1'b0;
    check("z_dump_valid", 32'(bus1.dump_valid), 32'd1);
    check("z_dump0", bus1.dump_data, 32'd0);
    n = 0;
    while (!bus1.dump_done && n < 40) begin
      if (bus1.dump_valid && bus1.dump_addr == 4'd1) check("z_dump1", bus1.dump_data, 32'h55);
      tick();
      n++;
    end
    check("z_dump_len", 32'(n), 32'd12);
    tick();
    check("z_busy_after", 32'(bus1.dump_busy), 32'd0);

    tick();
    check("rd_sb_left", 32'(q_rd1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the processor datapath: two registered read ports, one write port, an optional hardwired-zero register, same-cycle write-to-read forwarding, and a handshaked dump engine that streams the whole bank to a debug/display consumer. It sits between decode (read addresses) and writeback (write port). The dump port feeds the board-level register viewer without stalling the pipeline.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of registers (2..256)
- AW, $clog2(NUM_REGS), address width (derived; do not override)
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  sample read addresses this cycle
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  DATA_W  registered read data
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  DATA_W  write data
- dump_req  in  1  start-of-dump pulse/level, sampled in IDLE only
- dump_busy  out  1  dump in progress (RUN or DONE)
- dump_valid  out  1  dump_addr/dump_data valid
- dump_ready  in  1  consumer accepts current entry
- dump_addr  out  AW  index of current entry
- dump_data  out  DATA_W  live contents of bank[dump_addr]
- dump_done  out  1  one-cycle pulse after last entry accepted

## Operation
- Reset (rst=0, asynchronous): all bank entries, rd1, rd2, dump_addr = 0; dump_valid, dump_busy, dump_done = 0; FSM = IDLE.
- Write: at rising edge with we=1 and wa<NUM_REGS, bank[wa] <= wd. wa>=NUM_REGS ignored. With ZERO_REG=1, wa=0 ignored.
- Read: at rising edge with rd_en=1, rdN <= bank[raN] (or forwarded value, see Configuration). With rd_en=0, rd1/rd2 hold. raN>=NUM_REGS or (ZERO_REG=1 and raN=0) returns 0.
- Dump FSM:
  - IDLE: dump_valid=0. dump_req=1 -> RUN, dump_addr=0.
  - RUN: dump_valid=1, dump_busy=1. On dump_valid&&dump_ready: if dump_addr=NUM_REGS-1 -> DONE; else dump_addr+1. Stalled (ready=0): addr holds.
  - DONE: dump_valid=0, dump_done=1 for exactly one cycle, dump_busy=1 -> IDLE, dump_addr=0.
  - dump_req outside IDLE ignored; a held dump_req restarts a dump the cycle after DONE.
- dump_data is combinational from bank[dump_addr]; a write to dump_addr while stalled changes dump_data before acceptance (consumer gets newest value). ZERO_REG rules apply.
- Dump never blocks reads or writes.

## Timing
- Write latency: 1 cycle (visible to a read sampled the next edge).
- Read latency: 1 cycle from rd_en edge to rd1/rd2.
- Dump: first entry valid 1 cycle after dump_req sampled; full dump minimum NUM_REGS+2 cycles from req to done pulse (req->RUN, NUM_REGS accepts, DONE).
- Simultaneous we and rd_en to same address: see Configuration.
- Reset mid-dump: FSM to IDLE immediately, no dump_done pulse.

## Configuration
- RF_BYPASS_EN defined: when rd_en=1, we=1, wa=raN, write legal, rdN captures wd (write-first).
- Undefined: rdN captures the pre-write bank value (read-first); new value visible on the next read.
- Write itself unaffected either way.

## Test plan
- Reset: drive rst=0 mid-traffic -> rd1=rd2=0, dump_valid=0, all 16 entries read back 0 after release.
- Write/read: we, wa=5, wd=0xDEADBEEF; next cycle rd_en, ra1=5, ra2=3 -> rd1=0xDEADBEEF, rd2=0 one cycle later; rd_en=0 holds values.
- Same-cycle hazard: bank[7]=0x11, then we wa=7 wd=0x22 with rd_en ra1=7 -> rd1=0x22 with RF_BYPASS_EN, 0x11 without.
- ZERO_REG=1: write 0x1234 to reg 0 -> read returns 0; dump entry 0 shows 0.
- Dump with backpressure: load reg i = i*3, dump_req, dump_ready toggling 1/0 -> 16 accepted entries in order 0..15 with data i*3, single dump_done pulse, dump_busy low after.
- Dump corner: stall at addr 4, write 0xAA to reg 4 -> dump_data becomes 0xAA before acceptance; rst=0 at addr 9 -> IDLE, no dump_done.
